// File: rtl/silly_pkg.sv
// Shared definitions for the serial mask loader: opcodes, FSM states and
// the opcode decode used when a complete frame is applied.
package silly_pkg;

    localparam logic [7:0] OP_LOAD = 8'h01;
    localparam logic [7:0] OP_SET  = 8'h02;
    localparam logic [7:0] OP_CLR  = 8'h03;
    localparam logic [7:0] OP_TGL  = 8'h04;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        APPLY = 3'd2,
        DRAIN = 3'd3,
        ABORT = 3'd4
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [7:0] mask;
    } op_result_t;

    // Illegal opcodes return the current mask untouched with legal cleared.
    function automatic op_result_t apply_op(input logic [7:0] cur,
                                            input logic [7:0] op,
                                            input logic [7:0] data);
        op_result_t r;
        r.legal = 1'b1;
        r.mask  = cur;
        case (op)
            OP_LOAD: r.mask = data;
            OP_SET:  r.mask = cur | data;
            OP_CLR:  r.mask = cur & ~data;
            OP_TGL:  r.mask = cur ^ data;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/silly_mask_loader_if.sv
// 3-wire serial host link: frame select, serial clock and serial data.
interface silly_mask_loader_if;

    logic cs_n_pin;
    logic sclk_pin;
    logic sdata_pin;

    modport master (output cs_n_pin, output sclk_pin, output sdata_pin);
    modport slave  (input  cs_n_pin, input  sclk_pin, input  sdata_pin);

endinterface

// File: rtl/silly_sync.sv
// Single-bit multi-flop synchronizer for pins asynchronous to clk.
module silly_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/silly_mask_loader.sv
// Serial command front-end: receives 16-bit opcode/data frames and holds
// the 8-bit mask driven to the downstream AND stage.
module silly_mask_loader
    import silly_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_MASK  = 8'h00
) (
    input  logic                clk,
    input  logic                rst_n,
    silly_mask_loader_if.slave  ser,
    output logic [7:0]          mask_out,
    output logic                mask_stb,
    output logic                err_stb,
    output logic                busy
);

    logic cs_n_s;
    logic sclk_s;
    logic sdata_s;

    // Idle cs_n is high, so its synchronizer resets high to avoid a false frame start.
    silly_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk(clk), .rst_n(rst_n), .d(ser.cs_n_pin), .q(cs_n_s)
    );
    silly_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(ser.sclk_pin), .q(sclk_s)
    );
    silly_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdata (
        .clk(clk), .rst_n(rst_n), .d(ser.sdata_pin), .q(sdata_s)
    );

    logic        sclk_prev;
    logic        sclk_rise;
    state_t      state;
    logic [15:0] shreg;
    logic [4:0]  bit_cnt;
    op_result_t  res;

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign res       = apply_op(mask_out, shreg[15:8], shreg[7:0]);

    // NOTE: every flop here, including the shift register, has a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev <= 1'b0;
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            mask_out  <= RESET_MASK;
            mask_stb  <= 1'b0;
            err_stb   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sclk_prev <= sclk_s;
            mask_stb  <= 1'b0;
            err_stb   <= 1'b0;

            case (state)
                IDLE: begin
                    if (!cs_n_s) begin
                        bit_cnt <= '0;
                        state   <= SHIFT;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    // An edge coincident with cs_n rising is still taken, so
                    // a 16th bit arriving with cs_n completes the frame.
                    if (sclk_rise) begin
                        shreg   <= {shreg[14:0], sdata_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            state <= APPLY;
                        end else if (cs_n_s) begin
                            state <= ABORT;
                        end
                    end else if (cs_n_s) begin
                        state <= ABORT;
                    end
                end
                APPLY: begin
                    if (res.legal) begin
                        mask_out <= res.mask;
                        mask_stb <= 1'b1;
                    end else begin
                        err_stb  <= 1'b1;
                    end
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (cs_n_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ABORT: begin
                    err_stb <= 1'b1;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_silly_mask_loader.sv
// Self-checking bench for silly_mask_loader: directed frames from the test
// plan plus random frames checked against an opcode-level mask model.
module tb_silly_mask_loader;

    localparam int         HALF = 4;        // sclk half period in clk cycles
    localparam logic [7:0] RM   = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mask_out;
    logic       mask_stb;
    logic       err_stb;
    logic       busy;

    silly_mask_loader_if ser ();

    silly_mask_loader #(.SYNC_STAGES(2), .RESET_MASK(RM)) dut (
        .clk(clk), .rst_n(rst_n), .ser(ser),
        .mask_out(mask_out), .mask_stb(mask_stb), .err_stb(err_stb), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stb_cnt = 0, err_cnt = 0, both_cnt = 0;
    int stb_cyc = 0, rise_cyc = 0;
    logic [7:0] ref_mask;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mask_stb) begin
            stb_cnt = stb_cnt + 1;
            stb_cyc = cyc;
        end
        if (err_stb) err_cnt = err_cnt + 1;
        if (mask_stb && err_stb) both_cnt = both_cnt + 1;
    end

    // Reference: {legal, new mask} from the opcode table.
    function automatic logic [8:0] model(input logic [7:0] m, input logic [15:0] f);
        logic [7:0] d;
        d = f[7:0];
        case (f[15:8])
            8'h01:   return {1'b1, d};
            8'h02:   return {1'b1, m | d};
            8'h03:   return {1'b1, m & ~d};
            8'h04:   return {1'b1, m ^ d};
            default: return {1'b0, m};
        endcase
    endfunction

    task automatic do_bit(input logic b);
        ser.sclk_pin  = 1'b0;
        ser.sdata_pin = b;
        repeat (HALF) @(negedge clk);
        ser.sclk_pin = 1'b1;
        rise_cyc = cyc;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) do_bit(bits[i]);
    endtask

    task automatic start_frame();
        ser.cs_n_pin = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic end_frame();
        ser.sclk_pin = 1'b0;
        repeat (HALF) @(negedge clk);
        ser.cs_n_pin = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic run_frame(input logic [15:0] f, input logic [7:0] want);
        int s0, e0;
        logic [8:0] r;
        s0 = stb_cnt;
        e0 = err_cnt;
        r  = model(ref_mask, f);
        start_frame();
        send_bits({16'h0, f}, 16);
        end_frame();
        total++;
        if (mask_out !== r[7:0] || mask_out !== want) begin
            bad++;
            $display("FAIL frame_%h mask: got %h want %h", f, mask_out, want);
        end
        total++;
        if ((stb_cnt - s0) != (r[8] ? 1 : 0) || (err_cnt - e0) != (r[8] ? 0 : 1)) begin
            bad++;
            $display("FAIL frame_%h strobes: got stb=%0d err=%0d want legal=%0d",
                     f, stb_cnt - s0, err_cnt - e0, r[8]);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_%h busy_after: got %b want 0", f, busy);
        end
        ref_mask = r[7:0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ser.cs_n_pin = 1'b1;
        ser.sclk_pin = 1'b0;
        ser.sdata_pin = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (mask_out !== RM || mask_stb !== 1'b0 || err_stb !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got mask=%h stb=%b err=%b busy=%b want %h/0/0/0",
                     mask_out, mask_stb, err_stb, busy, RM);
        end
        rst_n = 1'b1;
        ref_mask = RM;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_load();
        run_frame(16'h01A5, 8'hA5);
        total++;
        if (stb_cyc - rise_cyc != 4) begin
            bad++;
            $display("FAIL load_latency: got %0d cycles want 4", stb_cyc - rise_cyc);
        end
    endtask

    task automatic test_ops();
        run_frame(16'h020F, 8'hAF);
        run_frame(16'h03A0, 8'h0F);
        run_frame(16'h04FF, 8'hF0);
    endtask

    task automatic test_illegal();
        run_frame(16'h7EFF, 8'hF0);
    endtask

    task automatic test_abort();
        int s0, e0;
        s0 = stb_cnt;
        e0 = err_cnt;
        start_frame();
        send_bits(32'h0100 >> 7, 9);
        ser.cs_n_pin = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        total++;
        if ((err_cnt - e0) != 1 || (stb_cnt - s0) != 0) begin
            bad++;
            $display("FAIL abort_strobes: got err=%0d stb=%0d want 1/0", err_cnt - e0, stb_cnt - s0);
        end
        total++;
        if (mask_out !== ref_mask || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: got mask=%h busy=%b want %h/0", mask_out, busy, ref_mask);
        end
        run_frame(16'h015A, 8'h5A);
    endtask

    task automatic test_overrun();
        int s0, e0;
        s0 = stb_cnt;
        e0 = err_cnt;
        start_frame();
        send_bits({8'h0, 16'h013C, 8'hFF}, 24);
        end_frame();
        total++;
        if (mask_out !== 8'h3C || (stb_cnt - s0) != 1 || (err_cnt - e0) != 0) begin
            bad++;
            $display("FAIL overrun: got mask=%h stb=%0d err=%0d want 3c/1/0",
                     mask_out, stb_cnt - s0, err_cnt - e0);
        end
        ref_mask = 8'h3C;
    endtask

    task automatic test_reset_mid();
        int e0;
        bit seen;
        start_frame();
        send_bits(32'h04, 8);
        ser.sclk_pin = 1'b0;
        repeat (HALF) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (mask_out !== RM || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_state: got mask=%h busy=%b want %h/0", mask_out, busy, RM);
        end
        ref_mask = RM;
        @(negedge clk);
        rst_n = 1'b1;
        e0 = err_cnt;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_busy_early: got %b want 0", busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL reset_mid_reenter: busy got 0 want 1 within 10 cycles");
        end
        ser.cs_n_pin = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        total++;
        if ((err_cnt - e0) != 1 || busy !== 1'b0 || mask_out !== RM) begin
            bad++;
            $display("FAIL reset_mid_abort: got err=%0d busy=%b mask=%h want 1/0/%h",
                     err_cnt - e0, busy, mask_out, RM);
        end
    endtask

    task automatic test_random();
        logic [15:0] f;
        logic [8:0]  r;
        int          sel;
        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(0, 5);
            f[15:8] = (sel < 4) ? 8'(sel + 1) : 8'($urandom);
            f[7:0]  = 8'($urandom);
            r = model(ref_mask, f);
            run_frame(f, r[7:0]);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load();
        test_ops();
        test_illegal();
        test_abort();
        test_overrun();
        test_reset_mid();
        test_random();
        total++;
        if (both_cnt != 0) begin
            bad++;
            $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", both_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
